// File: rtl/pcm_frame_buffer.sv
// Ping-pong frame buffer: gathers PCM samples into FRAME_LEN frames and replays each frame on a valid/ready stream.
// Latency: out_valid rises two edges after the edge that writes a frame's last sample (read FSM idle); 1 sample/cycle after that.
// Backpressure: out_ready low holds the output stable; with both banks busy, input samples are dropped and counted.
module pcm_frame_buffer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FULL, BANK_READING} bank_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM} rd_state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(FRAME_LEN - 2);

    logic [DATA_W-1:0] mem_a [FRAME_LEN];
    logic [DATA_W-1:0] mem_b [FRAME_LEN];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    bank_state_t       bank_st [2];
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_ptr;
    logic              discard;
    logic              last_done;   // bank that completed most recently

    rd_state_t         rd_state;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_ptr;

    logic              hs;
    logic              release_bank;
    logic              discard_eff;
    logic              wbank;
    logic              wr_go;
    logic              other_free;
    logic              full_a;
    logic              full_b;
    logic              pick;
    logic              pick_vld;
    logic [ADDR_W-1:0] rd_addr;

    // Handshake, bank release and write-bank resolution; a release frees its bank before the write side looks for space
    always_comb begin
        hs           = out_valid && out_ready;
        release_bank = (rd_state == RD_STREAM) && hs && out_last;
        discard_eff  = discard && !release_bank;
        // Leaving DISCARD, the only bank that can be free is the one just released by the reader
        wbank        = discard ? rd_bank : wr_bank;
        wr_go        = in_valid && !discard_eff;
        other_free   = (bank_st[~wbank] == BANK_EMPTY) || (release_bank && (rd_bank == ~wbank));
        full_a       = (bank_st[0] == BANK_FULL);
        full_b       = (bank_st[1] == BANK_FULL);
        // With two full banks the older frame is the one that did not complete last
        pick         = (full_a && full_b) ? ~last_done : full_b;
        pick_vld     = full_a || full_b;
        // Read one ahead on a handshake so the next sample is ready without a bubble; otherwise re-read the current one
        rd_addr      = (rd_state == RD_STREAM && hs) ? rd_ptr + ADDR_W'(1) : rd_ptr;
    end

    // Bank storage: plain write port plus registered read port per bank
    always_ff @(posedge clk) begin
        if (wr_go && !wbank) begin
            mem_a[wr_ptr] <= in_sample;
        end
        if (wr_go && wbank) begin
            mem_b[wr_ptr] <= in_sample;
        end
        rd_a <= mem_a[rd_addr];
        rd_b <= mem_b[rd_addr];
    end

    assign out_data  = rd_bank ? rd_b : rd_a;
    assign out_index = rd_ptr;

    // Bank states, write pointer/bank, drop accounting and the read FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            wr_bank    <= 1'b0;
            wr_ptr     <= '0;
            discard    <= 1'b0;
            last_done  <= 1'b0;
            rd_state   <= RD_IDLE;
            rd_bank    <= 1'b0;
            rd_ptr     <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (pick_vld) begin
                        bank_st[pick] <= BANK_READING;
                        rd_bank       <= pick;
                        rd_ptr        <= '0;
                        rd_state      <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    rd_state  <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (hs) begin
                        if (out_last) begin
                            bank_st[rd_bank] <= BANK_EMPTY;
                            out_valid        <= 1'b0;
                            out_last         <= 1'b0;
                            rd_ptr           <= '0;
                            rd_state         <= RD_IDLE;
                        end else begin
                            rd_ptr   <= rd_ptr + ADDR_W'(1);
                            out_last <= (rd_ptr == PRE_LAST);
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase

            if (wr_go) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (wr_ptr == LAST_IDX) begin
                    bank_st[wbank] <= BANK_FULL;
                    last_done      <= wbank;
                    if (other_free) begin
                        wr_bank <= ~wbank;
                        discard <= 1'b0;
                    end else begin
                        wr_bank <= wbank;
                        discard <= 1'b1;
                    end
                end else begin
                    wr_bank <= wbank;
                    discard <= 1'b0;
                end
            end else if (discard && release_bank) begin
                wr_bank <= rd_bank;
                discard <= 1'b0;
            end

            if (in_valid && discard_eff) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

endmodule
